txn_ring_buffer: RTL and testbench

Parametrised circular byte buffer with transactional writes. A producer streams a frame speculatively, then either commits it, making it visible to the consumer, or aborts it, discarding everything written since the last commit. It sits between packet assemblers and the host/serial drain path. It uses the full DEPTH capacity, gives a registered read port, and reports committed, pending and free levels plus sticky error flags.

---
 rtl/txn_ring_buffer_pkg.sv | 25 ++
 rtl/sdp_ram.sv | 33 +++
 rtl/txn_ring_buffer.sv | 118 +++++++++++
 tb/tb_txn_ring_buffer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/txn_ring_buffer_pkg.sv
// Shared types, helpers and error-flag layout for the transactional ring buffer.
package txn_ring_buffer_pkg;

  // Ceiling log2, used to size addresses and pointers from DEPTH.
  function automatic int unsigned u_log2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Bit positions of the sticky flags when packed into a status word.
  localparam int unsigned ERR_OVERFLOW_BIT  = 0;
  localparam int unsigned ERR_UNDERFLOW_BIT = 1;
  localparam int unsigned ERR_CMD_BIT       = 2;

  typedef struct packed {
    logic err_cmd;
    logic underflow;
    logic overflow;
  } err_flags_t;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
module sdp_ram import txn_ring_buffer_pkg::*; #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 512,
  localparam int unsigned ADDR_W    = u_log2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  (* ramstyle = "M20K" *) logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Write port; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Registered read; output holds its last value when no read is issued.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/txn_ring_buffer.sv
// Circular byte buffer with speculative writes that are committed or aborted as a frame.
module txn_ring_buffer import txn_ring_buffer_pkg::*; #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned AFULL_LEVEL = 480,
  localparam int unsigned ADDR_W     = u_log2(DEPTH),
  localparam int unsigned CNT_W      = ADDR_W + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_commit,
  input  logic                  i_abort,
  input  logic                  i_rd_en,
  input  logic                  i_clr_err,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid,
  output logic [CNT_W-1:0]      o_count,
  output logic [CNT_W-1:0]      o_pending,
  output logic [CNT_W-1:0]      o_free,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_almost_full,
  output logic                  o_overflow,
  output logic                  o_underflow,
  output logic                  o_err_cmd
);

  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cmt_ptr_q, cmt_ptr_d;
  logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
  err_flags_t       err_q, err_d;
  logic             rd_valid_q;

  logic [CNT_W-1:0] count_c, pending_c, occ_c, free_c;
  logic             cmd_conflict_c, abort_only_c;
  logic             wr_accept_c, wr_drop_c, rd_accept_c, rd_under_c;

  // Levels derived from registered pointers; modulo arithmetic handles wrap.
  always_comb begin
    count_c   = cmt_ptr_q - rd_ptr_q;
    pending_c = wr_ptr_q - cmt_ptr_q;
    occ_c     = wr_ptr_q - rd_ptr_q;
    free_c    = CNT_W'(DEPTH) - occ_c;
  end

  // Accept/refuse decisions, all against pre-edge levels.
  always_comb begin
    cmd_conflict_c = i_commit && i_abort;
    abort_only_c   = i_abort && !i_commit;
    wr_accept_c    = i_wr_en && (free_c != '0) && !abort_only_c;
    wr_drop_c      = i_wr_en && (free_c == '0) && !abort_only_c;
    rd_accept_c    = i_rd_en && (count_c != '0);
    rd_under_c     = i_rd_en && (count_c == '0);
  end

  // Next-state for pointers and sticky flags; a new error outranks a clear.
  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    cmt_ptr_d = cmt_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    err_d     = err_q;
    if (i_clr_err) err_d = '0;
    if (wr_accept_c) wr_ptr_d = wr_ptr_q + CNT_W'(1);
    if (!cmd_conflict_c) begin
      if (i_commit)     cmt_ptr_d = wr_ptr_q + CNT_W'(wr_accept_c);
      else if (i_abort) wr_ptr_d  = cmt_ptr_q;
    end
    if (rd_accept_c) rd_ptr_d = rd_ptr_q + CNT_W'(1);
    if (wr_drop_c)      err_d.overflow  = 1'b1;
    if (rd_under_c)     err_d.underflow = 1'b1;
    if (cmd_conflict_c) err_d.err_cmd   = 1'b1;
  end

  // State registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr_q   <= '0;
      cmt_ptr_q  <= '0;
      wr_ptr_q   <= '0;
      err_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      cmt_ptr_q  <= cmt_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      err_q      <= err_d;
      rd_valid_q <= rd_accept_c;
    end
  end

  sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .we_i    (wr_accept_c),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i (i_wr_data),
    .re_i    (rd_accept_c),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (o_rd_data)
  );

  assign o_rd_valid    = rd_valid_q;
  assign o_count       = count_c;
  assign o_pending     = pending_c;
  assign o_free        = free_c;
  assign o_empty       = (count_c == '0);
  assign o_full        = (free_c == '0);
  assign o_almost_full = (occ_c >= CNT_W'(AFULL_LEVEL));
  assign o_overflow    = err_q.overflow;
  assign o_underflow   = err_q.underflow;
  assign o_err_cmd     = err_q.err_cmd;

endmodule

// File: tb/tb_txn_ring_buffer.sv
// Directed self-checking bench for txn_ring_buffer.
module tb_txn_ring_buffer;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 512;
  localparam int unsigned CW    = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en, commit, abort, rd_en, clr_err;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;
  logic          rd_valid, empty, full, afull, ovf, unf, ecmd;
  logic [CW-1:0] count, pending, free;

  int vectors    = 0;
  int miscompares = 0;

  txn_ring_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_LEVEL(480)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_data(wr_data),
    .i_commit(commit), .i_abort(abort), .i_rd_en(rd_en), .i_clr_err(clr_err),
    .o_rd_data(rd_data), .o_rd_valid(rd_valid), .o_count(count),
    .o_pending(pending), .o_free(free), .o_empty(empty), .o_full(full),
    .o_almost_full(afull), .o_overflow(ovf), .o_underflow(unf), .o_err_cmd(ecmd)
  );

  always #5 clk = ~clk;

  // Advance past one rising edge; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 0; commit = 0; abort = 0; rd_en = 0; clr_err = 0; wr_data = '0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    repeat (2) step();
    vectors++; if (count !== 10'd0 || pending !== 10'd0 || free !== 10'd512) begin miscompares++; $display("FAIL reset_levels: got c=%0d p=%0d f=%0d, want 0/0/512", count, pending, free); end
    vectors++; if ({empty, full, afull} !== 3'b100) begin miscompares++; $display("FAIL reset_status: got e/f/af=%b, want 100", {empty, full, afull}); end
    vectors++; if ({ovf, unf, ecmd, rd_valid} !== 4'b0000 || rd_data !== 8'h00) begin miscompares++; $display("FAIL reset_flags: got flags=%b data=%h, want 0000/00", {ovf, unf, ecmd, rd_valid}, rd_data); end
    rst_n = 1;
    step();
    vectors++; if (count !== 10'd0 || free !== 10'd512 || empty !== 1'b1) begin miscompares++; $display("FAIL post_reset: got c=%0d f=%0d e=%b, want 0/512/1", count, free, empty); end
  endtask

  task automatic test_commit_read();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1; wr_data = 8'(8'h10 + i);
      step();
    end
    idle();
    vectors++; if (count !== 10'd0 || pending !== 10'd5 || free !== 10'd507) begin miscompares++; $display("FAIL spec_write: got c=%0d p=%0d f=%0d, want 0/5/507", count, pending, free); end
    commit = 1; step(); commit = 0;
    vectors++; if (count !== 10'd5 || pending !== 10'd0) begin miscompares++; $display("FAIL commit5: got c=%0d p=%0d, want 5/0", count, pending); end
    rd_en = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++; if (rd_valid !== 1'b1 || rd_data !== 8'(8'h10 + i)) begin miscompares++; $display("FAIL read5[%0d]: got v=%b d=%h, want 1/%h", i, rd_valid, rd_data, 8'(8'h10 + i)); end
    end
    rd_en = 0; step();
    vectors++; if (rd_valid !== 1'b0 || empty !== 1'b1 || rd_data !== 8'h14) begin miscompares++; $display("FAIL read5_done: got v=%b e=%b d=%h, want 0/1/14", rd_valid, empty, rd_data); end
  endtask

  task automatic test_abort();
    for (int i = 0; i < 3; i++) begin
      wr_en = 1; wr_data = 8'(8'h30 + i); commit = (i == 2);
      step();
    end
    idle();
    vectors++; if (count !== 10'd3 || pending !== 10'd0) begin miscompares++; $display("FAIL commit_same_cycle: got c=%0d p=%0d, want 3/0", count, pending); end
    for (int i = 0; i < 4; i++) begin
      wr_en = 1; wr_data = 8'(8'h40 + i);
      step();
    end
    wr_en = 1; wr_data = 8'hEE; abort = 1; step(); idle();
    vectors++; if (pending !== 10'd0 || count !== 10'd3 || ovf !== 1'b0) begin miscompares++; $display("FAIL abort: got p=%0d c=%0d ovf=%b, want 0/3/0", pending, count, ovf); end
    rd_en = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (rd_valid !== 1'b1 || rd_data !== 8'(8'h30 + i)) begin miscompares++; $display("FAIL abort_read[%0d]: got v=%b d=%h, want 1/%h", i, rd_valid, rd_data, 8'(8'h30 + i)); end
    end
    step(); rd_en = 0;
    vectors++; if (rd_valid !== 1'b0 || unf !== 1'b1) begin miscompares++; $display("FAIL underflow: got v=%b unf=%b, want 0/1", rd_valid, unf); end
    clr_err = 1; step(); clr_err = 0;
    vectors++; if (unf !== 1'b0) begin miscompares++; $display("FAIL clr_underflow: got %b, want 0", unf); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 512; i++) begin
      wr_en = 1; wr_data = 8'(i);
      step();
      if (i == 478) begin
        vectors++; if (afull !== 1'b0) begin miscompares++; $display("FAIL afull_479: got %b, want 0", afull); end
      end
      if (i == 479) begin
        vectors++; if (afull !== 1'b1) begin miscompares++; $display("FAIL afull_480: got %b, want 1", afull); end
      end
    end
    idle();
    commit = 1; step(); commit = 0;
    vectors++; if ({full, afull} !== 2'b11 || count !== 10'd512 || free !== 10'd0) begin miscompares++; $display("FAIL full: got f/af=%b c=%0d fr=%0d, want 11/512/0", {full, afull}, count, free); end
    wr_en = 1; wr_data = 8'hAA; step(); wr_en = 0;
    vectors++; if (ovf !== 1'b1 || count !== 10'd512 || pending !== 10'd0) begin miscompares++; $display("FAIL overflow: got ovf=%b c=%0d p=%0d, want 1/512/0", ovf, count, pending); end
    clr_err = 1; step(); clr_err = 0;
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL clr_overflow: got %b, want 0", ovf); end
    rd_en = 1; wr_en = 1; wr_data = 8'hBB; step(); wr_en = 0;
    vectors++; if (ovf !== 1'b1 || rd_valid !== 1'b1 || rd_data !== 8'h00 || count !== 10'd511 || free !== 10'd1) begin miscompares++; $display("FAIL full_rdwr: got ovf=%b v=%b d=%h c=%0d f=%0d, want 1/1/00/511/1", ovf, rd_valid, rd_data, count, free); end
    for (int i = 1; i < 512; i++) begin
      step();
      vectors++; if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin miscompares++; $display("FAIL full_read[%0d]: got v=%b d=%h, want 1/%h", i, rd_valid, rd_data, 8'(i)); end
    end
    rd_en = 0; clr_err = 1; step(); clr_err = 0;
    vectors++; if (empty !== 1'b1 || ovf !== 1'b0 || unf !== 1'b0) begin miscompares++; $display("FAIL full_drain: got e=%b ovf=%b unf=%b, want 1/0/0", empty, ovf, unf); end
  endtask

  task automatic test_wrap();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 300; i++) begin
        wr_en = 1; wr_data = 8'(r * 7 + i); commit = (i == 299);
        step();
      end
      idle();
      vectors++; if (count !== 10'd300 || pending !== 10'd0) begin miscompares++; $display("FAIL wrap_commit[%0d]: got c=%0d p=%0d, want 300/0", r, count, pending); end
      rd_en = 1;
      for (int i = 0; i < 300; i++) begin
        step();
        vectors++; if (rd_valid !== 1'b1 || rd_data !== 8'(r * 7 + i) || count !== 10'(299 - i)) begin miscompares++; $display("FAIL wrap_read[%0d][%0d]: got v=%b d=%h c=%0d, want 1/%h/%0d", r, i, rd_valid, rd_data, count, 8'(r * 7 + i), 299 - i); end
      end
      rd_en = 0; step();
    end
    vectors++; if (empty !== 1'b1 || unf !== 1'b0) begin miscompares++; $display("FAIL wrap_end: got e=%b unf=%b, want 1/0", empty, unf); end
  endtask

  task automatic test_same_cycle();
    commit = 1; abort = 1; wr_en = 1; wr_data = 8'h55; step(); idle();
    vectors++; if (ecmd !== 1'b1 || pending !== 10'd1 || count !== 10'd0) begin miscompares++; $display("FAIL cmd_conflict: got ecmd=%b p=%0d c=%0d, want 1/1/0", ecmd, pending, count); end
    clr_err = 1; rd_en = 1; step(); idle();
    vectors++; if (unf !== 1'b1 || ecmd !== 1'b0 || rd_valid !== 1'b0) begin miscompares++; $display("FAIL set_beats_clear: got unf=%b ecmd=%b v=%b, want 1/0/0", unf, ecmd, rd_valid); end
    clr_err = 1; abort = 1; step(); idle();
    vectors++; if (unf !== 1'b0 || pending !== 10'd0) begin miscompares++; $display("FAIL same_cycle_cleanup: got unf=%b p=%0d, want 0/0", unf, pending); end
  endtask

  task automatic test_reset_midframe();
    wr_en = 1; wr_data = 8'hA0; step();
    wr_data = 8'hA1; commit = 1; step(); idle();
    commit = 1; abort = 1; step(); idle();
    for (int i = 0; i < 7; i++) begin
      wr_en = 1; wr_data = 8'(8'hB0 + i);
      step();
    end
    idle();
    vectors++; if (count !== 10'd2 || pending !== 10'd7 || ecmd !== 1'b1) begin miscompares++; $display("FAIL pre_reset: got c=%0d p=%0d ecmd=%b, want 2/7/1", count, pending, ecmd); end
    #2 rst_n = 0;
    #1;
    vectors++; if (count !== 10'd0 || pending !== 10'd0 || free !== 10'd512 || {empty, full, afull} !== 3'b100) begin miscompares++; $display("FAIL async_reset_levels: got c=%0d p=%0d f=%0d e/f/af=%b, want 0/0/512/100", count, pending, free, {empty, full, afull}); end
    vectors++; if ({ovf, unf, ecmd, rd_valid} !== 4'b0000 || rd_data !== 8'h00) begin miscompares++; $display("FAIL async_reset_flags: got %b d=%h, want 0000/00", {ovf, unf, ecmd, rd_valid}, rd_data); end
    step(); rst_n = 1; step();
  endtask

  initial begin
    test_reset();
    test_commit_read();
    test_abort();
    test_full();
    test_wrap();
    test_same_cycle();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
